// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: address-width calculation and
// the DEPTH legality check.
package fifo_pkg;

  localparam int unsigned MIN_DEPTH = 2;

  // Number of bits needed to address n entries (ceil(log2(n))).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (((n - 1) >> i) != 0) r = r + 1;
    end
    return r;
  endfunction

  // DEPTH must be a power of 2 and at least MIN_DEPTH.
  function automatic bit depth_ok(input int unsigned n);
    return (n >= MIN_DEPTH) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port and one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen.sv
// Synchronous FIFO with occupancy count, almost flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_gen
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       din,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("sync_fifo_gen: DEPTH must be a power of 2 and >= 2");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic [DATA_W-1:0] rd_data_c;

  // Status is a pure function of the registered pointers.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (32'(count) >= AF_LEVEL);
  assign almost_empty = (32'(count) <= AE_LEVEL);

  assign wr_acc_c = wr_en && !full;
  assign rd_acc_c = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + PTR_W'(1);
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (wr_acc_c),
    .waddr   (wr_ptr[ADDR_W-1:0]),
    .wdata   (din),
    .raddr   (rd_ptr[ADDR_W-1:0]),
    .rdata_c (rd_data_c)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is always visible; blanked while nothing is stored.
  assign dout = empty ? '0 : rd_data_c;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_acc_c) begin
      dout <= rd_data_c;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Self-checking bench for sync_fifo_gen (standard read mode, DEPTH=16).
module tb_sync_fifo_gen;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_udf;
  bit         cmp_en = 1'b0;

  sync_fifo_gen #(
    .DATA_W   (8),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: acceptance decided from occupancy before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      int n;
      n = q.size();
      m_ovf = wr_en && (n == DEPTH);
      m_udf = rd_en && (n == 0);
      if (rd_en && n != 0) m_dout = q.pop_front();
      if (wr_en && n != DEPTH) q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_count", int'(count), q.size());
      chk("m_empty", int'(empty), int'(q.size() == 0));
      chk("m_full", int'(full), int'(q.size() == DEPTH));
      chk("m_afull", int'(almost_full), int'(q.size() >= AF));
      chk("m_aempty", int'(almost_empty), int'(q.size() <= AE));
      chk("m_dout", int'(dout), int'(m_dout));
      chk("m_overflow", int'(overflow), int'(m_ovf));
      chk("m_underflow", int'(underflow), int'(m_udf));
    end
  end

  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_afull", int'(almost_full), int'((i + 1) >= 14));
      chk("fill_full", int'(full), int'(i == 15));
    end
    chk("fill_count", int'(count), 16);

    // Overflow while full
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", int'(overflow), 0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_dout", int'(dout), i);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);

    // Underflow while empty
    step(1'b0, 8'h00, 1'b1);
    chk("udf_pulse", int'(underflow), 1);
    chk("udf_dout", int'(dout), 8'h0F);
    step(1'b0, 8'h00, 1'b0);
    chk("udf_clear", int'(underflow), 0);

    // Empty with write and read: only the write lands
    step(1'b1, 8'h11, 1'b1);
    chk("we_count", int'(count), 1);
    chk("we_udf", int'(underflow), 1);
    chk("we_dout", int'(dout), 8'h0F);
    step(1'b0, 8'h00, 1'b1);
    chk("we_read", int'(dout), 8'h11);

    // Wrap with simultaneous traffic at count=5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 8'(8'h30 + k), 1'b1);
      chk("wrap_count", int'(count), 5);
      chk("wrap_dout", int'(dout), (k < 5) ? (8'h20 + k) : (8'h30 + k - 5));
    end

    // Full with write and read: only the read lands
    for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    chk("wf_full", int'(full), 1);
    step(1'b1, 8'hBB, 1'b1);
    chk("wf_ovf", int'(overflow), 1);
    chk("wf_count", int'(count), 15);
    chk("wf_dout", int'(dout), 8'h53);

    // Bring occupancy to 9, then reset mid-cycle
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("pre_rst_count", int'(count), 9);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_dout", int'(dout), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Old entries are gone; fresh write reads back alone
    step(1'b1, 8'h77, 1'b0);
    chk("post_count", int'(count), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_dout", int'(dout), 8'h77);
    chk("post_empty", int'(empty), 1);
    step(1'b0, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_gen.md
SYNC_FIFO_GEN -- requirements
Module: sync_fifo_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of 2, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in entries.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port din  input  DATA_W  write data.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port dout  output  DATA_W  read data.
REQ-011 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-012 SHALL have port count  output  ADDR_W+1  current occupancy, where ADDR_W = log2(DEPTH).
REQ-013 SHALL have port overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-014 Write SHALL be accepted iff wr_en=1 and full=0; din is stored at wr_ptr and wr_ptr advances by 1.
REQ-015 Read SHALL be accepted iff rd_en=1 and empty=0; rd_ptr advances by 1.
REQ-016 Pointers SHALL be ADDR_W+1 bits; the low ADDR_W bits address memory, and the MSB toggles on wrap from DEPTH-1 to 0.
REQ-017 empty SHALL be 1 iff wr_ptr==rd_ptr; full SHALL be 1 iff the MSBs differ and the low bits are equal.
REQ-018 count SHALL equal wr_ptr-rd_ptr modulo 2^(ADDR_W+1), ranging from 0 to DEPTH.
REQ-019 almost_full SHALL be 1 iff count>=AF_LEVEL; almost_empty SHALL be 1 iff count<=AE_LEVEL.
REQ-020 All flags and count SHALL be derived from registered pointers only, with no combinational path from wr_en/rd_en.
REQ-021 Simultaneous accepted write and read SHALL leave count unchanged, with both pointers advancing.
REQ-022 When full=1, wr_en=1 and rd_en=1 in the same cycle, only the read SHALL be accepted.
REQ-023 When empty=1, wr_en=1 and rd_en=1 in the same cycle, only the write SHALL be accepted.
REQ-024 In standard mode, dout SHALL register the entry at rd_ptr one cycle after an accepted read.
REQ-025 In standard mode, dout SHALL hold its last value when no read is accepted; it is not cleared.
REQ-026 overflow SHALL pulse high for exactly one cycle, the cycle after wr_en=1 with full=1; storage and pointers are unchanged.
REQ-027 underflow SHALL pulse high for exactly one cycle, the cycle after rd_en=1 with empty=1; dout and pointers are unchanged.

Reset
REQ-028 rst=1 SHALL immediately clear wr_ptr, rd_ptr, dout, overflow and underflow to 0, giving empty=1, almost_empty=1, full=0, almost_full=0 and count=0.
REQ-029 rst asserted mid-operation SHALL discard all stored entries; memory contents are not cleared and are unobservable after reset.

Configuration
REQ-030 With macro FIFO_FWFT_EN defined, dout SHALL continuously present the entry at rd_ptr whenever empty=0, and an accepted read pops it with 0-cycle read latency.
REQ-031 With FIFO_FWFT_EN defined, dout SHALL be 0 while empty=1, and a word written into an empty FIFO SHALL appear on dout the cycle after the write.
REQ-032 Without FIFO_FWFT_EN, behaviour SHALL be standard mode per REQ-024 and REQ-025.

Structure
REQ-033 Package fifo_pkg SHALL hold the clog2 helper function and the DEPTH power-of-2 legality check constant.
REQ-034 Storage SHALL be a sub-module fifo_ram (1 write port, 1 read port, DATA_W x DEPTH, synchronous write) instantiated once.

Verification (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-035 Fill test: write 0x00..0x0F with no reads -> full=1 after the 16th write, count=16, almost_full=1 from count=14.
REQ-036 Drain and ordering test: read 16 times -> dout sequence 0x00..0x0F, empty=1 after the last read, count=0.
REQ-037 Overflow and underflow test: while full, wr_en=1 with din=0xAA -> overflow pulses for 1 cycle and 0xAA is never read; while empty, rd_en=1 -> underflow pulses for 1 cycle.
REQ-038 Wrap and simultaneous test: 40 cycles of wr_en=rd_en=1 at count=5 -> count stays 5, pointers wrap, and data order is preserved.
REQ-039 Async reset test: assert rst mid-cycle at count=9 -> count=0 and empty=1 before the next clk edge.
REQ-040 FWFT test (FIFO_FWFT_EN defined): write 0x5C into an empty FIFO -> dout=0x5C the next cycle with no rd_en required.
